// File: rtl/axi_wr_fifo_router.sv
// AXI4 write-burst slave that steers each burst's beats into one of NCH
// destination FIFOs chosen by awaddr[7:4], and answers with a write response.
module axi_wr_fifo_router #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int IDX_W  = 10,
    parameter int NCH    = 2
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ID_W-1:0]       axs_s0_awid,
    input  logic [31:0]           axs_s0_awaddr,
    input  logic [7:0]            axs_s0_awlen,
    input  logic                  axs_s0_awvalid,
    output logic                  axs_s0_awready,

    input  logic [DATA_W-1:0]     axs_s0_wdata,
    input  logic [DATA_W/8-1:0]   axs_s0_wstrb,
    input  logic                  axs_s0_wlast,
    input  logic                  axs_s0_wvalid,
    output logic                  axs_s0_wready,

    output logic [ID_W-1:0]       axs_s0_bid,
    output logic [1:0]            axs_s0_bresp,
    output logic                  axs_s0_bvalid,
    input  logic                  axs_s0_bready,

    input  logic [NCH-1:0]        ch_full,
    output logic [NCH-1:0]        ch_push,
    output logic [NCH-1:0]        ch_clr,
    output logic [DATA_W-1:0]     ch_data,
    output logic [DATA_W/8-1:0]   ch_strb,
    output logic                  ch_last,
    output logic [IDX_W-1:0]      ch_index
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_BRESP = 3'd3;

    localparam logic [4:0] NCH_L = 5'(NCH);

    logic [2:0]        r_state;
    logic [ID_W-1:0]   r_awid;
    logic [31:0]       r_awaddr;
    logic [7:0]        r_awlen;
    logic [7:0]        r_beatCnt;
    logic              r_protoErr;
    logic [IDX_W-1:0]  r_index;

    logic [3:0]        w_sel;
    logic              w_modeLast;
    logic              w_decErr;
    logic [NCH-1:0]    w_selOh;
    logic              w_selFull;
    logic              w_inData;
    logic              w_beat;
    logic              w_finalBeat;
    logic              w_unused;

    assign w_sel      = r_awaddr[7:4];
    assign w_modeLast = r_awaddr[0];
    assign w_decErr   = ({1'b0, w_sel} >= NCH_L);

    // One-hot channel select; all zero when the address decodes past NCH.
    always_comb begin
        w_selOh = '0;
        for (int i = 0; i < NCH; i++) begin
            w_selOh[i] = ({1'b0, w_sel} == 5'(i));
        end
    end

    assign w_selFull   = |(ch_full & w_selOh);
    assign w_inData    = (r_state == S_WDATA);
    assign w_finalBeat = (r_beatCnt == 8'd0);

    // Decode-error bursts are drained at full rate so the master never stalls.
    assign axs_s0_wready  = w_inData & (w_decErr | ~w_selFull);
    assign w_beat         = axs_s0_wvalid & axs_s0_wready;

    assign axs_s0_awready = (r_state == S_IDLE);
    assign axs_s0_bvalid  = (r_state == S_BRESP);
    assign axs_s0_bid     = axs_s0_bvalid ? r_awid : '0;

    always_comb begin
        axs_s0_bresp = 2'b00;
        if (axs_s0_bvalid) begin
            if (w_decErr) begin
                axs_s0_bresp = 2'b11;
            end else if (r_protoErr) begin
                axs_s0_bresp = 2'b10;
            end
        end
    end

    assign ch_push  = (w_beat & ~w_decErr) ? w_selOh : '0;
    assign ch_data  = axs_s0_wdata;
    assign ch_strb  = axs_s0_wstrb;
    assign ch_last  = w_beat & ~w_decErr & w_finalBeat & w_modeLast;
    assign ch_clr   = ((r_state == S_INIT) && !reset) ? '1 : '0;
    assign ch_index = r_index;

    assign w_unused = ^{r_awaddr[31:8], r_awaddr[3:1], r_awlen};

    // Burst length always comes from awlen; wlast is only cross-checked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_awid     <= '0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_beatCnt  <= '0;
            r_protoErr <= 1'b0;
            r_index    <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_index <= '0;
                    r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (axs_s0_awvalid) begin
                        r_awid     <= axs_s0_awid;
                        r_awaddr   <= axs_s0_awaddr;
                        r_awlen    <= axs_s0_awlen;
                        r_beatCnt  <= axs_s0_awlen;
                        r_protoErr <= 1'b0;
                        r_state    <= S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (w_beat) begin
                        if (axs_s0_wlast != w_finalBeat) begin
                            r_protoErr <= 1'b1;
                        end
                        if (w_finalBeat) begin
                            r_state <= S_BRESP;
                            if (w_modeLast && !w_decErr) begin
                                r_index <= r_index + 1'b1;
                            end
                        end else begin
                            r_beatCnt <= r_beatCnt - 8'd1;
                        end
                    end
                end
                S_BRESP: begin
                    if (axs_s0_bready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_fifo_router.sv
// Directed bench for axi_wr_fifo_router: a transaction-level model predicts
// every FIFO push, write response and record index from the bursts issued.
module tb_axi_wr_fifo_router;

    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int IDX_W  = 2;
    localparam int NCH    = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [ID_W-1:0]      axs_s0_awid;
    logic [31:0]          axs_s0_awaddr;
    logic [7:0]           axs_s0_awlen;
    logic                 axs_s0_awvalid;
    logic                 axs_s0_awready;
    logic [DATA_W-1:0]    axs_s0_wdata;
    logic [DATA_W/8-1:0]  axs_s0_wstrb;
    logic                 axs_s0_wlast;
    logic                 axs_s0_wvalid;
    logic                 axs_s0_wready;
    logic [ID_W-1:0]      axs_s0_bid;
    logic [1:0]           axs_s0_bresp;
    logic                 axs_s0_bvalid;
    logic                 axs_s0_bready;
    logic [NCH-1:0]       ch_full;
    logic [NCH-1:0]       ch_push;
    logic [NCH-1:0]       ch_clr;
    logic [DATA_W-1:0]    ch_data;
    logic [DATA_W/8-1:0]  ch_strb;
    logic                 ch_last;
    logic [IDX_W-1:0]     ch_index;

    always #5 clk = ~clk;

    axi_wr_fifo_router #(
        .DATA_W(DATA_W), .ID_W(ID_W), .IDX_W(IDX_W), .NCH(NCH)
    ) dut (
        .clk(clk), .reset(reset),
        .axs_s0_awid(axs_s0_awid), .axs_s0_awaddr(axs_s0_awaddr),
        .axs_s0_awlen(axs_s0_awlen), .axs_s0_awvalid(axs_s0_awvalid),
        .axs_s0_awready(axs_s0_awready),
        .axs_s0_wdata(axs_s0_wdata), .axs_s0_wstrb(axs_s0_wstrb),
        .axs_s0_wlast(axs_s0_wlast), .axs_s0_wvalid(axs_s0_wvalid),
        .axs_s0_wready(axs_s0_wready),
        .axs_s0_bid(axs_s0_bid), .axs_s0_bresp(axs_s0_bresp),
        .axs_s0_bvalid(axs_s0_bvalid), .axs_s0_bready(axs_s0_bready),
        .ch_full(ch_full), .ch_push(ch_push), .ch_clr(ch_clr),
        .ch_data(ch_data), .ch_strb(ch_strb), .ch_last(ch_last),
        .ch_index(ch_index)
    );

    typedef struct {
        logic [NCH-1:0]      push;
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
    } pushRec_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } respRec_t;

    pushRec_t          expPush[$];
    respRec_t          expResp[$];
    logic [IDX_W-1:0]  mdlIndex = '0;
    bit                mdlInData = 1'b0;
    bit                mdlRoute = 1'b0;
    bit                mdlDecErr = 1'b0;
    int                mdlCh = 0;
    bit                checkEn = 1'b0;
    int                total = 0;
    int                bad = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the transaction model.
    always @(negedge clk) begin
        pushRec_t e;
        respRec_t r;
        if (checkEn && !reset) begin
            checkOutput("aw_w_exclusive", axs_s0_awready & axs_s0_wready, 0);
            checkOutput("w_b_exclusive", axs_s0_wready & axs_s0_bvalid, 0);
            checkOutput("clr_quiet", ch_clr, 0);
            checkOutput("wready", axs_s0_wready,
                        mdlInData && (mdlDecErr || !ch_full[mdlCh]));
            if (axs_s0_wvalid && axs_s0_wready && mdlRoute) begin
                if (expPush.size() == 0) begin
                    checkOutput("push_unexpected", ch_push, 0);
                end else begin
                    e = expPush.pop_front();
                    checkOutput("push_vec", ch_push, e.push);
                    checkOutput("push_data", ch_data, e.data);
                    checkOutput("push_strb", ch_strb, e.strb);
                    checkOutput("push_last", ch_last, e.last);
                end
            end else begin
                checkOutput("no_push", ch_push, 0);
                checkOutput("no_last", ch_last, 0);
            end
            if (axs_s0_bvalid && axs_s0_bready) begin
                if (expResp.size() == 0) begin
                    checkOutput("resp_unexpected", axs_s0_bvalid, 0);
                end else begin
                    r = expResp.pop_front();
                    checkOutput("bid", axs_s0_bid, r.id);
                    checkOutput("bresp", axs_s0_bresp, r.resp);
                end
            end
            if (axs_s0_awready || axs_s0_bvalid) begin
                checkOutput("index", ch_index, mdlIndex);
            end
        end
    end

    task automatic releaseReset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("clr_pulse", ch_clr, {NCH{1'b1}});
        checkOutput("init_awready", axs_s0_awready, 0);
        @(negedge clk);
        checkOutput("clr_done", ch_clr, 0);
        checkOutput("idle_awready", axs_s0_awready, 1);
        checkOutput("idle_index", ch_index, 0);
        checkEn = 1'b1;
        @(posedge clk); #1;
    endtask

    // One AXI write burst. badBeat flips wlast on that beat; stallAfter/stallLen
    // hold ch_full high after that many beats; resetAfter aborts via reset.
    task automatic applyStimulus(input logic [ID_W-1:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [DATA_W-1:0] base,
                                 input logic [DATA_W/8-1:0] strb, input int badBeat,
                                 input int stallAfter, input int stallLen, input int resetAfter,
                                 input logic [1:0] litResp, input int litIdx);
        int       n;
        bit       hs;
        int       ch;
        bit       dec;
        bit       mode;
        bit       protoErr;
        pushRec_t p;
        respRec_t r;
        logic [NCH-1:0] oh;

        ch   = int'(addr[7:4]);
        dec  = (ch >= NCH);
        mode = addr[0];
        protoErr = (badBeat >= 0) && (badBeat <= int'(len));
        oh = '0;
        if (!dec) oh[ch] = 1'b1;

        axs_s0_awid = id; axs_s0_awaddr = addr; axs_s0_awlen = len; axs_s0_awvalid = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 20) begin
            @(negedge clk); hs = axs_s0_awready;
            @(posedge clk); #1; n++;
        end
        axs_s0_awvalid = 1'b0;
        if (!hs) begin
            checkOutput("aw_timeout", 0, 1);
            return;
        end

        if (!dec) begin
            for (int b = 0; b <= int'(len); b++) begin
                p.push = oh; p.data = base + DATA_W'(b); p.strb = strb;
                p.last = mode && (b == int'(len));
                expPush.push_back(p);
            end
            if (mode) mdlIndex = mdlIndex + 1'b1;
        end
        r.id = id;
        r.resp = dec ? 2'b11 : (protoErr ? 2'b10 : 2'b00);
        expResp.push_back(r);
        mdlDecErr = dec; mdlCh = dec ? 0 : ch; mdlRoute = !dec; mdlInData = 1'b1;

        for (int b = 0; b <= int'(len); b++) begin
            axs_s0_wdata = base + DATA_W'(b);
            axs_s0_wstrb = strb;
            axs_s0_wlast = (b == int'(len)) ^ (b == badBeat);
            axs_s0_wvalid = 1'b1;
            n = 0; hs = 1'b0;
            while (!hs && n < 20) begin
                @(negedge clk); hs = axs_s0_wready;
                @(posedge clk); #1; n++;
            end
            if (!hs) begin
                checkOutput("w_timeout", 0, 1);
                axs_s0_wvalid = 1'b0; mdlInData = 1'b0; mdlRoute = 1'b0;
                return;
            end
            if (b == int'(len)) begin
                axs_s0_wvalid = 1'b0; mdlInData = 1'b0; mdlRoute = 1'b0;
            end
            if (b + 1 == resetAfter) begin
                axs_s0_wdata = base + DATA_W'(b + 1);
                axs_s0_wlast = 1'b0;
                checkOutput("pre_rst_wready", axs_s0_wready, 1);
                checkOutput("pre_rst_push", ch_push, oh);
                checkEn = 1'b0;
                reset = 1'b1;
                #1;
                checkOutput("rst_wready", axs_s0_wready, 0);
                checkOutput("rst_push", ch_push, 0);
                checkOutput("rst_bvalid", axs_s0_bvalid, 0);
                checkOutput("rst_index", ch_index, 0);
                axs_s0_wvalid = 1'b0;
                expPush.delete(); expResp.delete();
                mdlIndex = '0; mdlInData = 1'b0; mdlRoute = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                checkOutput("rst_no_resp", axs_s0_bvalid, 0);
                releaseReset();
                return;
            end
            if (b + 1 == stallAfter) begin
                ch_full = '1;
                repeat (stallLen) begin
                    @(negedge clk);
                    checkOutput("stall_wready", axs_s0_wready, 0);
                    @(posedge clk); #1;
                end
                ch_full = '0;
            end
        end

        @(negedge clk);
        checkOutput("bvalid_next", axs_s0_bvalid, 1);
        checkOutput("bid_lit", axs_s0_bid, id);
        checkOutput("bresp_lit", axs_s0_bresp, litResp);
        if (litIdx >= 0) checkOutput("index_lit", ch_index, litIdx);
        @(posedge clk); #1;
        axs_s0_bready = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 20) begin
            @(negedge clk); hs = axs_s0_bvalid;
            @(posedge clk); #1; n++;
        end
        axs_s0_bready = 1'b0;
        if (!hs) checkOutput("b_timeout", 0, 1);
        @(negedge clk);
        checkOutput("awready_after", axs_s0_awready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int idxSeq[5];
        idxSeq = '{1, 2, 3, 0, 1};
        reset = 1'b1;
        axs_s0_awid = '0; axs_s0_awaddr = '0; axs_s0_awlen = '0; axs_s0_awvalid = 1'b0;
        axs_s0_wdata = '0; axs_s0_wstrb = '0; axs_s0_wlast = 1'b0; axs_s0_wvalid = 1'b0;
        axs_s0_bready = 1'b0; ch_full = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_awready", axs_s0_awready, 0);
        checkOutput("reset_wready", axs_s0_wready, 0);
        checkOutput("reset_bvalid", axs_s0_bvalid, 0);
        checkOutput("reset_push", ch_push, 0);
        checkOutput("reset_last", ch_last, 0);
        checkOutput("reset_bresp", axs_s0_bresp, 0);
        checkOutput("reset_bid", axs_s0_bid, 0);
        checkOutput("reset_index", ch_index, 0);
        releaseReset();

        // Single normal-mode beat to channel 1.
        applyStimulus(4'h5, 32'h10, 8'd0, 32'hDEADBEEF, 4'hF, -1, -1, 0, -1, 2'b00, 0);
        // Last-mode burst to channel 0 with a two-cycle full stall after beat 1.
        applyStimulus(4'h3, 32'h01, 8'd3, 32'h1000_0000, 4'h5, -1, 1, 2, -1, 2'b00, 1);
        // Decode error, then early wlast protocol error.
        applyStimulus(4'hA, 32'h70, 8'd1, 32'hBAD0_0000, 4'hF, -1, -1, 0, -1, 2'b11, 1);
        applyStimulus(4'h6, 32'h00, 8'd1, 32'h2000_0000, 4'h3, 0, -1, 0, -1, 2'b10, 1);
        // Last-mode burst to channel 1.
        applyStimulus(4'h9, 32'h11, 8'd1, 32'h5000_0000, 4'hC, -1, -1, 0, -1, 2'b00, 2);
        // Reset after beat 2 of 4.
        applyStimulus(4'h2, 32'h01, 8'd3, 32'h3000_0000, 4'hF, -1, -1, 0, 2, 2'b00, -1);
        // Index wrap with a 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ID_W'(i), 32'h01, 8'd0, 32'h4000_0000 + DATA_W'(i), 4'hF,
                          -1, -1, 0, -1, 2'b00, idxSeq[i]);
        end

        checkOutput("push_drained", expPush.size(), 0);
        checkOutput("resp_drained", expResp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_wr_fifo_router.md
AXI_WR_FIFO_ROUTER -- requirements
Module: axi_wr_fifo_router

Interface
REQ-001 SHALL have parameter DATA_W, default 32: AXI write-data width and FIFO data width, a multiple of 8.
REQ-002 SHALL have parameter ID_W, default 4: AXI ID width.
REQ-003 SHALL have parameter IDX_W, default 10: record-index counter width.
REQ-004 SHALL have parameter NCH, default 2: number of destination FIFO channels, 1..16.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports axs_s0_awid/awaddr/awlen/awvalid, inputs, ID_W/32/8/1: AXI write address; axs_s0_awready, output, 1.
REQ-008 SHALL have ports axs_s0_wdata/wstrb/wlast/wvalid, inputs, DATA_W/DATA_W/8/1/1: AXI write data; axs_s0_wready, output, 1.
REQ-009 SHALL have ports axs_s0_bid/bresp/bvalid, outputs, ID_W/2/1: AXI write response; axs_s0_bready, input, 1.
REQ-010 SHALL have port ch_full, input, NCH: per-channel FIFO full flag.
REQ-011 SHALL have ports ch_push and ch_clr, outputs, NCH each: per-channel push and clear strobes.
REQ-012 SHALL have ports ch_data (DATA_W), ch_strb (DATA_W/8), ch_last (1) and ch_index (IDX_W), outputs: data, strobe, record-end flag and index, all shared by every channel.

Function
REQ-013 SHALL implement the states INIT, IDLE, WDATA and BRESP.
REQ-014 INIT SHALL last one cycle: ch_clr all ones, index cleared, then move to IDLE.
REQ-015 IDLE SHALL drive awready=1 and all other handshake outputs 0.
- On awvalid, latch awid, awaddr, awlen, and set beat counter = awlen.
- Then move to WDATA.
REQ-016 SHALL decode the latched address as follows:
- Channel sel = awaddr[7:4].
- Mode = awaddr[0]: 0 = normal, 1 = last.
- sel >= NCH is a decode error.
REQ-017 In WDATA with a valid sel, SHALL drive wready = ~ch_full[sel].
REQ-018 In WDATA with a valid sel, ch_push[sel] SHALL equal wvalid & wready in the same cycle, with no extra latency.
- ch_data = wdata and ch_strb = wstrb, combinational pass-through.
REQ-019 In WDATA with a decode error, SHALL drive wready=1, push nothing and discard the beats.
REQ-020 On each accepted beat, SHALL decrement the beat counter; the beat with counter==0 is the final beat.
REQ-021 After the final beat is accepted, SHALL move to BRESP on the next cycle.
REQ-022 ch_last SHALL be 1 only with the push of the final beat of a last-mode burst.
REQ-023 The index register SHALL increment by one on the cycle after that final beat.
- Wraps from 2^IDX_W-1 to 0.
- ch_index is the register value.
REQ-024 If wlast disagrees with the final-beat position on any accepted beat, SHALL record a protocol error.
- The burst length is still taken from awlen.
- Every beat is still pushed.
REQ-025 BRESP SHALL drive bvalid=1 and bid = latched awid.
- bresp = 2'b11 on a decode error, else 2'b10 on a protocol error, else 2'b00.
- Outputs hold until bready, then move to IDLE.
REQ-026 ch_full changing mid-burst SHALL only stall beats; no data is lost, duplicated or reordered.
REQ-027 SHALL never drive awready and wready together, and SHALL never drive wready together with bvalid.
REQ-028 An unreachable state encoding SHALL return to INIT.

Reset
REQ-029 While reset=1, asynchronously and immediately:
- state = INIT, index = 0, latched fields = 0.
- awready, wready, bvalid, ch_push, ch_last = 0.
- bresp = 0, bid = 0.
REQ-030 Reset during a burst SHALL abandon the burst with no response.
- After release, INIT is followed by IDLE.

Verification
REQ-031 Release reset -> exactly one cycle ch_clr=2'b11, then awready=1, ch_index=0.
REQ-032 awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wlast=1 -> one-cycle ch_push=2'b10 with ch_data=0xDEADBEEF, ch_last=0, then bvalid with bresp=00 and bid=awid, ch_index still 0.
REQ-033 awaddr=0x01, awlen=3, ch_full[0]=1 for two cycles after beat 1 -> wready=0 for those two cycles, exactly 4 pushes on ch_push[0] in order, ch_last on beat 4 only, ch_index 0->1.
REQ-034 IDX_W=2, five single-beat last-mode writes to 0x01 -> ch_index sequence 1,2,3,0,1.
REQ-035 NCH=2, awaddr=0x70, awlen=1 -> two beats accepted, ch_push stays 0, bresp=2'b11; awlen=1 to 0x00 with wlast on beat 1 -> 2 pushes, bresp=2'b10.
REQ-036 Reset asserted mid-burst after beat 2 of 4 -> wready and ch_push drop in the same cycle, no bvalid, ch_index=0, INIT clear pulse after release.
